// File: rtl/alu_share_sched.sv
// alu_share_sched
//   Round-robin scheduler that shares one set of one's-complement arithmetic
//   units (add/sub, multiply, divide) between two requesters. One op is in
//   flight at a time. Its operands are latched and held stable for the op's
//   settle time. The result and underflow flag are registered and returned on
//   one tagged response channel.
//
//   Parameters: ADD_LAT / MUL_LAT / DIV_LAT - settle cycles per op class (>=1)
//   Optional build macro: DIV0_TRAP_EN
//     A DIV whose denominator is +0 or -0 skips EXEC. It returns
//     {15'h3FFF, 15'h0000} with rsp_uflow=1 one cycle after the handshake.
//
//   Ports:
//     clk, rst_n        clock; asynchronous active-low reset
//     req_valid[1:0]    per-requester request
//     req_ready[1:0]    per-requester accept, at most one bit high, IDLE only
//     reqN_op/a/b       op (0 ADD, 1 SUB, 2 MUL, 3 DIV), 30-bit A, 15-bit B
//     rsp_valid/ready   response handshake
//     rsp_id            requester that issued the op
//     rsp_data          30-bit one's-complement result
//     rsp_uflow         2c->1c conversion underflow from mult/div
//
//   Divide: the 30-bit numerator carries its integer part in [29:15].
//   The result is {quotient, remainder} of that integer part by B.
//   Quotient sign = sign(A) ^ sign(B); remainder sign = sign(A).
//   A zero divisor returns a quotient magnitude of 15'h3FFF and flags underflow.
module alu_share_sched #(
    parameter int unsigned ADD_LAT = 1,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned DIV_LAT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req0_op,
    input  logic [29:0] req0_a,
    input  logic [14:0] req0_b,
    input  logic [1:0]  req1_op,
    input  logic [29:0] req1_a,
    input  logic [14:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [29:0] rsp_data,
    output logic        rsp_uflow
);

    localparam int unsigned MAX_LAT = (ADD_LAT > MUL_LAT)
        ? ((ADD_LAT > DIV_LAT) ? ADD_LAT : DIV_LAT)
        : ((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT);
    localparam int unsigned CNT_W = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, HOLD = 2'd2} state_t;
    typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3} op_t;

    // one's-complement add with end-around carry; a single fold suffices
    function automatic logic [14:0] oc_add(input logic [14:0] x, input logic [14:0] y);
        logic [15:0] s;
        s = {1'b0, x} + {1'b0, y};
        return s[14:0] + {14'd0, s[15]};
    endfunction

    // returns {uflow, product}
    function automatic logic [30:0] oc_mult(input logic [14:0] x, input logic [14:0] y);
        logic [14:0] mx, my;
        logic [29:0] mag;
        mx  = x[14] ? ~x : x;
        my  = y[14] ? ~y : y;
        mag = {15'd0, mx} * {15'd0, my};
        return {mag[29], (x[14] ^ y[14]) ? ~mag : mag};
    endfunction

    // returns {uflow, quotient, remainder}; nh is the numerator integer part
    function automatic logic [30:0] oc_div(input logic [14:0] nh, input logic [14:0] d);
        logic [14:0] mn, md, q, r;
        logic        fl;
        mn = nh[14] ? ~nh : nh;
        md = d[14] ? ~d : d;
        if (md == '0) begin
            q  = 15'h3FFF;
            r  = '0;
            fl = 1'b1;
        end else begin
            q  = mn / md;
            r  = mn % md;
            fl = 1'b0;
        end
        return {fl, (nh[14] ^ d[14]) ? ~q : q, nh[14] ? ~r : r};
    endfunction

    state_t            state, state_nx;
    op_t               op_q, sel_op;
    logic [29:0]       a_q, sel_a;
    logic [14:0]       b_q, sel_b;
    logic              id_q, last_grant, grant, any_valid, hs, trap, capture, rsp_fire;
    logic [CNT_W-1:0]  cnt, sel_cnt;
    logic [14:0]       sum;
    logic [30:0]       mres, dres;
    logic [29:0]       res_data;
    logic              res_uflow;

    // arbitration and operand select
    always_comb begin
        any_valid = |req_valid;
        grant     = (&req_valid) ? ~last_grant : req_valid[1];
        sel_op    = op_t'(grant ? req1_op : req0_op);
        sel_a     = grant ? req1_a : req0_a;
        sel_b     = grant ? req1_b : req0_b;
        unique case (sel_op)
            OP_MUL:  sel_cnt = CNT_W'(MUL_LAT - 1);
            OP_DIV:  sel_cnt = CNT_W'(DIV_LAT - 1);
            default: sel_cnt = CNT_W'(ADD_LAT - 1);
        endcase
`ifdef DIV0_TRAP_EN
        trap = (sel_op == OP_DIV) && ((sel_b == '0) || (sel_b == '1));
`else
        trap = 1'b0;
`endif
    end

    // shared arithmetic units, driven only by the latched operands
    always_comb begin
        sum       = oc_add(a_q[14:0], (op_q == OP_SUB) ? ~b_q : b_q);
        mres      = oc_mult(a_q[14:0], b_q);
        dres      = oc_div(a_q[29:15], b_q);
        res_data  = {{15{sum[14]}}, sum};
        res_uflow = 1'b0;
        unique case (op_q)
            OP_MUL:  {res_uflow, res_data} = mres;
            OP_DIV:  {res_uflow, res_data} = dres;
            default: ;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // FSM: next state
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (hs) state_nx = trap ? HOLD : EXEC;
            EXEC:    if (cnt == '0) state_nx = HOLD;
            HOLD:    if (rsp_fire) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM: outputs and strobes
    always_comb begin
        req_ready = '0;
        if (state == IDLE && any_valid) req_ready[grant] = 1'b1;
        hs       = |req_ready;
        capture  = (state == EXEC) && (cnt == '0);
        rsp_fire = rsp_valid && rsp_ready;
    end

    // Operand latch and response registers. rsp_valid is a registered stage
    // behind HOLD entry, which gives the LAT+1 request-to-response latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= OP_ADD;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_uflow  <= 1'b0;
        end else begin
            if (hs) begin
                op_q       <= sel_op;
                a_q        <= sel_a;
                b_q        <= sel_b;
                id_q       <= grant;
                last_grant <= grant;
                cnt        <= sel_cnt;
                if (trap) begin
                    rsp_data  <= {15'h3FFF, 15'h0000};
                    rsp_uflow <= 1'b1;
                    rsp_id    <= grant;
                end
            end
            if (state == EXEC && cnt != '0) cnt <= cnt - CNT_W'(1);
            if (capture) begin
                rsp_data  <= res_data;
                rsp_uflow <= res_uflow;
                rsp_id    <= id_q;
            end
            rsp_valid <= (state == HOLD) && !rsp_fire;
        end
    end

endmodule

// File: tb/tb_alu_share_sched.sv
module tb_alu_share_sched;

    localparam int unsigned ADD_LAT = 1;
    localparam int unsigned MUL_LAT = 3;
    localparam int unsigned DIV_LAT = 8;
    localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req0_op, req1_op;
    logic [29:0] req0_a, req1_a;
    logic [14:0] req0_b, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_uflow;
    logic [29:0] rsp_data;

    int vecs = 0;
    int errs = 0;

    alu_share_sched #(.ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_uflow(rsp_uflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // present a request and wait (bounded) for its handshake edge
    task automatic issue(input logic id, input logic [1:0] op, input logic [29:0] a,
                         input logic [14:0] b, output bit ok);
        ok = 1'b0;
        if (id) begin req1_op = op; req1_a = a; req1_b = b; end
        else    begin req0_op = op; req0_a = a; req0_b = b; end
        req_valid[id] = 1'b1;
        #1;
        for (int i = 0; i < 50; i++) begin
            if (req_ready[id]) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        req_valid[id] = 1'b0;
    endtask

    // edges from handshake until rsp_valid is first seen; -1 on timeout
    task automatic wait_rsp(output int lat);
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (rsp_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        vecs++; if (req_ready !== 2'b00) begin errs++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
        vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        vecs++; if (rsp_id !== 1'b0) begin errs++; $display("FAIL reset_rsp_id got %b want 0", rsp_id); end
        vecs++; if (rsp_data !== 30'd0) begin errs++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
        vecs++; if (rsp_uflow !== 1'b0) begin errs++; $display("FAIL reset_rsp_uflow got %b want 0", rsp_uflow); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [1:0]  rdy_exp[3] = '{2'b01, 2'b10, 2'b01};
        logic [29:0] dat_exp[3] = '{30'd3, 30'd11, 30'd3};
        int lat;
        req0_op = OP_ADD; req0_a = 30'd1; req0_b = 15'd2;
        req1_op = OP_ADD; req1_a = 30'd5; req1_b = 15'd6;
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 50; i++) begin
                if (req_ready != 2'b00) break;
                @(posedge clk); #1;
            end
            vecs++; if (req_ready !== rdy_exp[k]) begin errs++; $display("FAIL rr_ready[%0d] got %b want %b", k, req_ready, rdy_exp[k]); end
            @(posedge clk); #1;
            vecs++; if (req_ready !== 2'b00) begin errs++; $display("FAIL rr_ready_busy[%0d] got %b want 00", k, req_ready); end
            if (k == 2) req_valid = 2'b00;
            wait_rsp(lat);
            vecs++; if (rsp_id !== rdy_exp[k][1]) begin errs++; $display("FAIL rr_id[%0d] got %b want %b", k, rsp_id, rdy_exp[k][1]); end
            vecs++; if (rsp_data !== dat_exp[k]) begin errs++; $display("FAIL rr_data[%0d] got %h want %h", k, rsp_data, dat_exp[k]); end
            consume();
        end
    endtask

    task automatic test_add_sub();
        logic        ids[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0]  ops[4] = '{OP_ADD, OP_SUB, OP_SUB, OP_ADD};
        logic [29:0] as[4]  = '{30'd3, 30'd5, 30'd3, 30'h7FFF};
        logic [14:0] bs[4]  = '{15'h7FFE, 15'd3, 15'd5, 15'd3};
        logic [29:0] ex[4]  = '{30'd2, 30'd2, 30'h3FFF_FFFD, 30'd3};
        bit ok;
        int lat;
        for (int k = 0; k < 4; k++) begin
            issue(ids[k], ops[k], as[k], bs[k], ok);
            vecs++; if (!ok) begin errs++; $display("FAIL addsub_hs[%0d] got no handshake want handshake", k); end
            wait_rsp(lat);
            vecs++; if (lat != int'(ADD_LAT) + 1) begin errs++; $display("FAIL addsub_lat[%0d] got %0d want %0d", k, lat, ADD_LAT + 1); end
            vecs++; if (rsp_data !== ex[k]) begin errs++; $display("FAIL addsub_data[%0d] got %h want %h", k, rsp_data, ex[k]); end
            vecs++; if (rsp_id !== ids[k]) begin errs++; $display("FAIL addsub_id[%0d] got %b want %b", k, rsp_id, ids[k]); end
            vecs++; if (rsp_uflow !== 1'b0) begin errs++; $display("FAIL addsub_uflow[%0d] got %b want 0", k, rsp_uflow); end
            consume();
            vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL addsub_drop[%0d] got %b want 0", k, rsp_valid); end
        end
    endtask

    task automatic test_mul_div();
        logic        ids[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [1:0]  ops[4] = '{OP_MUL, OP_MUL, OP_DIV, OP_DIV};
        logic [29:0] as[4]  = '{30'd3, 30'h7FFC, 30'd3276800, ~30'd3276800};
        logic [14:0] bs[4]  = '{15'd5, 15'd5, 15'd7, 15'd7};
        logic [29:0] ex[4]  = '{30'd15, 30'h3FFF_FFF0, {15'd14, 15'd2}, {15'h7FF1, 15'h7FFD}};
        int          lx[4]  = '{MUL_LAT + 1, MUL_LAT + 1, DIV_LAT + 1, DIV_LAT + 1};
        bit ok;
        int lat;
        for (int k = 0; k < 4; k++) begin
            issue(ids[k], ops[k], as[k], bs[k], ok);
            vecs++; if (!ok) begin errs++; $display("FAIL muldiv_hs[%0d] got no handshake want handshake", k); end
            wait_rsp(lat);
            vecs++; if (lat != lx[k]) begin errs++; $display("FAIL muldiv_lat[%0d] got %0d want %0d", k, lat, lx[k]); end
            vecs++; if (rsp_data !== ex[k]) begin errs++; $display("FAIL muldiv_data[%0d] got %h want %h", k, rsp_data, ex[k]); end
            vecs++; if (rsp_id !== ids[k]) begin errs++; $display("FAIL muldiv_id[%0d] got %b want %b", k, rsp_id, ids[k]); end
            vecs++; if (rsp_uflow !== 1'b0) begin errs++; $display("FAIL muldiv_uflow[%0d] got %b want 0", k, rsp_uflow); end
            consume();
        end
    endtask

    task automatic test_stall();
        bit ok;
        int lat;
        issue(1'b1, OP_MUL, 30'd3, 15'd5, ok);
        wait_rsp(lat);
        vecs++; if (lat != int'(MUL_LAT) + 1) begin errs++; $display("FAIL stall_lat got %0d want %0d", lat, MUL_LAT + 1); end
        req0_op = OP_ADD; req1_op = OP_ADD;
        req_valid = 2'b11;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            vecs++; if ({rsp_valid, rsp_id, req_ready} !== 4'b1100) begin errs++; $display("FAIL stall_ctl[%0d] got %b want 1100", c, {rsp_valid, rsp_id, req_ready}); end
            vecs++; if (rsp_data !== 30'd15) begin errs++; $display("FAIL stall_data[%0d] got %h want %h", c, rsp_data, 30'd15); end
        end
        req_valid = 2'b00;
        consume();
        vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL stall_release got %b want 0", rsp_valid); end
        vecs++; if (rsp_data !== 30'd15) begin errs++; $display("FAIL stall_keep got %h want %h", rsp_data, 30'd15); end
    endtask

    task automatic test_reset_mid_op();
        bit ok;
        bit seen;
        issue(1'b0, OP_DIV, 30'd3276800, 15'd7, ok);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        vecs++; if ({rsp_valid, rsp_id, rsp_uflow, req_ready} !== 5'b0) begin errs++; $display("FAIL midrst_ctl got %b want 00000", {rsp_valid, rsp_id, rsp_uflow, req_ready}); end
        vecs++; if (rsp_data !== 30'd0) begin errs++; $display("FAIL midrst_data got %h want 0", rsp_data); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        vecs++; if (seen !== 1'b0) begin errs++; $display("FAIL midrst_no_rsp got %b want 0", seen); end
    endtask

    task automatic test_div_zero();
        logic [14:0] bs[2] = '{15'h0000, 15'h7FFF};
`ifdef DIV0_TRAP_EN
        int          lx[2] = '{1, 1};
        logic [29:0] ex[2] = '{{15'h3FFF, 15'h0000}, {15'h3FFF, 15'h0000}};
`else
        int          lx[2] = '{DIV_LAT + 1, DIV_LAT + 1};
        logic [29:0] ex[2] = '{{15'h3FFF, 15'h0000}, {15'h4000, 15'h0000}};
`endif
        bit ok;
        int lat;
        for (int k = 0; k < 2; k++) begin
            issue(1'b0, OP_DIV, 30'd3276800, bs[k], ok);
            vecs++; if (!ok) begin errs++; $display("FAIL div0_hs[%0d] got no handshake want handshake", k); end
            wait_rsp(lat);
            vecs++; if (lat != lx[k]) begin errs++; $display("FAIL div0_lat[%0d] got %0d want %0d", k, lat, lx[k]); end
            vecs++; if (rsp_data !== ex[k]) begin errs++; $display("FAIL div0_data[%0d] got %h want %h", k, rsp_data, ex[k]); end
            vecs++; if (rsp_uflow !== 1'b1) begin errs++; $display("FAIL div0_uflow[%0d] got %b want 1", k, rsp_uflow); end
            consume();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        req0_op = OP_ADD; req0_a = '0; req0_b = '0;
        req1_op = OP_ADD; req1_a = '0; req1_b = '0;
        test_reset();
        test_round_robin();
        test_add_sub();
        test_mul_div();
        test_stall();
        test_reset_mid_op();
        test_div_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
